// File: rtl/fpga_cfg_pkg.sv
// Shared types and constants for the word-wide FPGA configuration loader.
// Single-bit CRC-16-CCITT step lives here so the CRC sub-module stays a thin register.
package fpga_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        CHK   = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } cfg_state_t;

    localparam logic [15:0] CFG_MAGIC = 16'hF9A0;

    localparam logic [1:0] ERR_MAGIC = 2'd1;
    localparam logic [1:0] ERR_LEN   = 2'd2;
    localparam logic [1:0] ERR_CRC   = 2'd3;

    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'h1021;

    function automatic logic [15:0] crc16_bit(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/fpga_cfg_crc16.sv
// CRC-16-CCITT accumulator absorbing NUM_CHAINS bits per enabled cycle, bit 0 first.
module fpga_cfg_crc16
    import fpga_cfg_pkg::*;
#(
    parameter int NUM_CHAINS = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  clr,
    input  logic                  en,
    input  logic [NUM_CHAINS-1:0] din,
    output logic [15:0]           crc
);

    logic [15:0] crc_r;
    logic [15:0] crc_nxt_s;

    // fold the per-cycle chain bits into the running CRC
    always_comb begin
        crc_nxt_s = crc_r;
        for (int k = 0; k < NUM_CHAINS; k++) begin
            crc_nxt_s = crc16_bit(crc_nxt_s, din[k]);
        end
    end

    // CRC register with clear taking priority over update
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            crc_r <= CRC_INIT;
        end else if (clr) begin
            crc_r <= CRC_INIT;
        end else if (en) begin
            crc_r <= crc_nxt_s;
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/fpga_cfg_loader.sv
// Framed, CRC-checked loader that serialises payload words across NUM_CHAINS CRAM chains.
// Optional chain-tail readback capture is enabled by defining FPGA_CFG_READBACK_EN.
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int NUM_CHAINS = 4,
    parameter int CHAIN_LEN  = 1024
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic [WORD_W-1:0]     s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [NUM_CHAINS-1:0] cfg_en,
    output logic [NUM_CHAINS-1:0] cfg_data,
    input  logic [NUM_CHAINS-1:0] cfg_rb,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [WORD_W-1:0]     rb_data,
    output logic                  rb_valid
);

    localparam int SPW   = WORD_W / NUM_CHAINS;
    localparam int WORDS = NUM_CHAINS * CHAIN_LEN / WORD_W;
    localparam int WCW   = $clog2(WORDS + 1);
    localparam int SCW   = (SPW > 1) ? $clog2(SPW) : 1;

    localparam logic [15:0]    WORDS_HDR = 16'(WORDS);
    localparam logic [WCW-1:0] WORDS_CNT = WCW'(WORDS);
    localparam logic [SCW-1:0] SH_LAST   = SCW'(SPW - 1);

    cfg_state_t            state_r;
    logic [WORD_W-1:0]     word_r;
    logic [SCW-1:0]        sh_r;
    logic [WCW-1:0]        wcnt_r;
    logic                  s_ready_r;
    logic [NUM_CHAINS-1:0] cfg_en_r;
    logic [NUM_CHAINS-1:0] cfg_data_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  err_r;
    logic [1:0]            err_code_r;

    logic        start_ok_s;
    logic        xfer_s;
    logic        shift_s;
    logic [15:0] crc_s;

    assign start_ok_s = start && ((state_r == IDLE) || (state_r == DONE) || (state_r == ERR));
    assign xfer_s     = s_valid && s_ready_r;
    assign shift_s    = (state_r == SHIFT);

    fpga_cfg_crc16 #(.NUM_CHAINS(NUM_CHAINS)) u_crc (
        .clk  (clk),
        .nrst (nrst),
        .clr  (start_ok_s),
        .en   (shift_s),
        .din  (cfg_data_r),
        .crc  (crc_s)
    );

    // frame sequencer; all outputs are registered alongside the state
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r    <= IDLE;
            word_r     <= '0;
            sh_r       <= '0;
            wcnt_r     <= '0;
            s_ready_r  <= 1'b0;
            cfg_en_r   <= '0;
            cfg_data_r <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= 2'd0;
        end else begin
            case (state_r)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state_r    <= HDR;
                        s_ready_r  <= 1'b1;
                        busy_r     <= 1'b1;
                        done_r     <= 1'b0;
                        err_r      <= 1'b0;
                        err_code_r <= 2'd0;
                        wcnt_r     <= '0;
                    end
                end
                HDR: begin
                    if (xfer_s) begin
                        if (s_data[31:16] != CFG_MAGIC) begin
                            state_r    <= ERR;
                            s_ready_r  <= 1'b0;
                            busy_r     <= 1'b0;
                            err_r      <= 1'b1;
                            err_code_r <= ERR_MAGIC;
                        end else if (s_data[15:0] != WORDS_HDR) begin
                            state_r    <= ERR;
                            s_ready_r  <= 1'b0;
                            busy_r     <= 1'b0;
                            err_r      <= 1'b1;
                            err_code_r <= ERR_LEN;
                        end else begin
                            state_r <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (xfer_s) begin
                        state_r    <= SHIFT;
                        s_ready_r  <= 1'b0;
                        word_r     <= s_data >> NUM_CHAINS;
                        cfg_data_r <= s_data[NUM_CHAINS-1:0];
                        cfg_en_r   <= '1;
                        sh_r       <= '0;
                        wcnt_r     <= wcnt_r + WCW'(1);
                    end
                end
                SHIFT: begin
                    // word_r holds only the not-yet-presented slices, lowest first
                    if (sh_r == SH_LAST) begin
                        cfg_en_r   <= '0;
                        cfg_data_r <= '0;
                        s_ready_r  <= 1'b1;
                        state_r    <= (wcnt_r == WORDS_CNT) ? CHK : LOAD;
                    end else begin
                        sh_r       <= sh_r + SCW'(1);
                        cfg_data_r <= word_r[NUM_CHAINS-1:0];
                        word_r     <= word_r >> NUM_CHAINS;
                    end
                end
                CHK: begin
                    if (xfer_s) begin
                        s_ready_r <= 1'b0;
                        busy_r    <= 1'b0;
                        if (s_data[15:0] == crc_s) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r    <= ERR;
                            err_r      <= 1'b1;
                            err_code_r <= ERR_CRC;
                        end
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    s_ready_r  <= 1'b0;
                    cfg_en_r   <= '0;
                    cfg_data_r <= '0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready  = s_ready_r;
    assign cfg_en   = cfg_en_r;
    assign cfg_data = cfg_data_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;
    assign err_code = err_code_r;

`ifdef FPGA_CFG_READBACK_EN
    logic [WORD_W-1:0] rb_r;
    logic              rb_valid_r;

    // capture chain tails slice by slice; pulse valid once the word is complete
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rb_r       <= '0;
            rb_valid_r <= 1'b0;
        end else begin
            rb_valid_r <= shift_s && (sh_r == SH_LAST);
            for (int j = 0; j < SPW; j++) begin
                if (shift_s && (sh_r == SCW'(j))) begin
                    rb_r[j*NUM_CHAINS +: NUM_CHAINS] <= cfg_rb;
                end
            end
        end
    end

    assign rb_data  = rb_r;
    assign rb_valid = rb_valid_r;
`else
    logic unused_rb_s;
    assign unused_rb_s = ^cfg_rb;
    assign rb_data     = '0;
    assign rb_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Scoreboard bench for fpga_cfg_loader with behavioural CRAM chain models attached.
`timescale 1ns/1ps
module tb_fpga_cfg_loader;

    localparam int WORD_W = 32;
    localparam int NC     = 4;
    localparam int CLEN   = 64;
    localparam int NW     = 8;
    localparam int SPW    = 8;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              start = 1'b0;
    logic [WORD_W-1:0] s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [NC-1:0]     cfg_en;
    logic [NC-1:0]     cfg_data;
    logic [NC-1:0]     cfg_rb;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic [WORD_W-1:0] rb_data;
    logic              rb_valid;

    always #5 clk = ~clk;

    fpga_cfg_loader #(.WORD_W(WORD_W), .NUM_CHAINS(NC), .CHAIN_LEN(CLEN)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .start    (start),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .cfg_en   (cfg_en),
        .cfg_data (cfg_data),
        .cfg_rb   (cfg_rb),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .rb_data  (rb_data),
        .rb_valid (rb_valid)
    );

    // chain models: shift in at bit 0, tail is the MSB
    logic [CLEN-1:0] chain [NC];
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < NC; k++) chain[k] <= '0;
        end else begin
            for (int k = 0; k < NC; k++)
                if (cfg_en[k]) chain[k] <= {chain[k][CLEN-2:0], cfg_data[k]};
        end
    end
    for (genvar k = 0; k < NC; k++) begin : g_rb
        assign cfg_rb[k] = chain[k][CLEN-1];
    end

    logic [31:0] pay [NW];
    logic [3:0]  exp_q [$];
    logic [31:0] rb_q [$];
    int n_checks = 0;
    int n_errs = 0;
    int en_cycles = 0;
    int rb_pulses = 0;
    int rdy_viol = 0;
    int en_viol = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_pay(input int p);
        case (p)
            0: pay = '{32'h0123_4567, 32'h89AB_CDEF, 32'hDEAD_BEEF, 32'hCAFE_F00D,
                       32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678};
            1: pay = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0F0F_0F0F, 32'hF0F0_F0F0,
                       32'h1357_9BDF, 32'h2468_ACE0, 32'h0000_0000, 32'h7FFF_FFFE};
            2: pay = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                       32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888};
            default: pay = '{32'h0BAD_F00D, 32'hFEED_FACE, 32'h0000_FFFF, 32'hFFFF_0000,
                             32'h3C3C_C3C3, 32'h6996_9669, 32'h8421_1248, 32'h0F1E_2D3C};
        endcase
    endtask

    function automatic logic [15:0] model_crc();
        logic [15:0] c;
        logic fb;
        c = 16'hFFFF;
        for (int w = 0; w < NW; w++)
            for (int j = 0; j < SPW; j++)
                for (int k = 0; k < NC; k++) begin
                    fb = c[15] ^ pay[w][j*NC+k];
                    c  = {c[14:0], 1'b0};
                    if (fb) c = c ^ 16'h1021;
                end
        return c;
    endfunction

    function automatic logic [CLEN-1:0] chain_exp(input int k);
        logic [CLEN-1:0] e;
        e = '0;
        for (int w = 0; w < NW; w++)
            for (int j = 0; j < SPW; j++)
                e[CLEN-1-(w*SPW+j)] = pay[w][j*NC+k];
        return e;
    endfunction

    task automatic check_chains(input string tag);
        for (int k = 0; k < NC; k++)
            check($sformatf("%s_chain%0d", tag, k), chain[k], chain_exp(k));
    endtask

    task automatic send(input logic [31:0] w, input bit bp);
        int g;
        int gap;
        g = 0;
        if (bp) begin
            gap = $urandom_range(0, 3);
            s_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        s_data  = w;
        s_valid = 1'b1;
        while (!s_ready && g < 100) begin
            @(negedge clk);
            g++;
            if (bp && !s_ready) s_valid = 1'($urandom_range(0, 1));
        end
        s_valid = 1'b1;
        check("ready_wait_bound", (g >= 100), 0);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic do_frame(input logic [31:0] hdr, input int nw, input logic [15:0] cx,
                            input logic [3:0] exp_res, input bit bp);
        logic [15:0] c;
        int g;
        c = model_crc() ^ cx;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ready_after_start", s_ready, 1);
        exp_q.push_back(exp_res);
        send(hdr, bp);
        for (int w = 0; w < nw; w++) send(pay[w], bp);
        if (nw > 0) send({16'h0000, c}, bp);
        check("fin_next_cycle", done | err, 1);
        check("busy_low_at_fin", busy, 0);
        g = 0;
        while (exp_q.size() > 0 && g < 10) begin
            @(negedge clk);
            g++;
        end
        check("result_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // monitor: pop expected outcomes / readback words as the DUT presents them
    initial begin : monitor
        logic prev_fin;
        prev_fin = 1'b0;
        forever begin
            @(negedge clk);
            if (nrst) begin
                if ((done || err) && !prev_fin) begin
                    check("result_pending", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check("result", {done, err, err_code}, exp_q.pop_front());
                end
                prev_fin = done || err;
                if (cfg_en != '0) en_cycles++;
                if (cfg_en != '0 && s_ready) rdy_viol++;
                if (cfg_en != '0 && cfg_en != 4'hF) en_viol++;
                if (cfg_en == '0 && cfg_data != '0) en_viol++;
                if (rb_valid) begin
                    rb_pulses++;
                    if (rb_q.size() > 0) check("readback", rb_data, rb_q.pop_front());
                end
            end else begin
                prev_fin = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int e0;
        int r0;
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", {s_ready, cfg_en, cfg_data, done, err, err_code, busy, rb_valid}, 0);
        check("reset_rb_data", rb_data, 0);
        nrst = 1'b1;
        @(negedge clk);

        load_pay(0);
        e0 = en_cycles;
        do_frame(32'hF9A0_0008, NW, 16'h0000, 4'b1000, 1'b0);
        check("good_en_cycles", en_cycles - e0, 64);
        check_chains("good");

        e0 = en_cycles;
        do_frame(32'hF9A1_0008, 0, 16'h0000, 4'b0101, 1'b0);
        check("magic_en_cycles", en_cycles - e0, 0);
        check("magic_busy", busy, 0);

        do_frame(32'hF9A0_0007, 0, 16'h0000, 4'b0110, 1'b0);
        load_pay(1);
        do_frame(32'hF9A0_0008, NW, 16'h0000, 4'b1000, 1'b0);
        check("relaunch_err_clear", {err, err_code}, 0);
        check_chains("relaunch");

        load_pay(2);
        do_frame(32'hF9A0_0008, NW, 16'h0001, 4'b0111, 1'b0);
        check_chains("crcbad");

        load_pay(3);
        e0 = en_cycles;
        do_frame(32'hF9A0_0008, NW, 16'h0000, 4'b1000, 1'b1);
        check("bp_en_cycles", en_cycles - e0, 64);
        check_chains("bp");
        check("ready_in_shift", rdy_viol, 0);
        check("cfg_idle_or_uneven", en_viol, 0);

        load_pay(0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send(32'hF9A0_0008, 1'b0);
        send(pay[0], 1'b0);
        repeat (2) @(negedge clk);
        check("mid_shift_en", cfg_en, 4'hF);
        nrst = 1'b0;
        #1;
        check("abort_outs", {s_ready, cfg_en, cfg_data, done, err, err_code, busy, rb_valid}, 0);
        check("abort_rb_data", rb_data, 0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        do_frame(32'hF9A0_0008, NW, 16'h0000, 4'b1000, 1'b0);
        check_chains("post_reset");

`ifdef FPGA_CFG_READBACK_EN
        load_pay(0);
        do_frame(32'hF9A0_0008, NW, 16'h0000, 4'b1000, 1'b0);
        r0 = rb_pulses;
        for (int w = 0; w < NW; w++) rb_q.push_back(pay[w]);
        load_pay(1);
        do_frame(32'hF9A0_0008, NW, 16'h0000, 4'b1000, 1'b0);
        check("rb_pulse_count", rb_pulses - r0, 8);
        check("rb_drained", rb_q.size(), 0);
`else
        r0 = 0;
        check("rb_pulses_none", rb_pulses - r0, 0);
        check("rb_data_zero", rb_data, 0);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
